// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX-stage hazard controller.
// The performance counters are enabled by defining HAZARD_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALL_PUSH = 2'd1,
    RET_POP   = 2'd2,
    REDIRECT  = 2'd3
  } hz_state_e;

  localparam int unsigned STACK_BEATS_DEF = 2;
  localparam int unsigned RTI_EXTRA_DEF   = 1;
  localparam int unsigned REG_AW          = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic busy;
  } hz_ctrl_t;

  function automatic logic src_match(input logic              uses,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] rd);
    return uses & (src == rd);
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter with a zero flag; tracks the remaining stack beats.
// Decrement saturates at zero so a stray dec never wraps.
module stall_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Stall/flush controller for load-use bubbles, taken jumps and CALL/RET/RTI stack sequences.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned STACK_BEATS = STACK_BEATS_DEF,
  parameter int unsigned RTI_EXTRA   = RTI_EXTRA_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_uses_src1,
  input  logic              id_uses_src2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_call,
  input  logic              ex_ret,
  input  logic              ex_rti,
  input  logic              ex_jump_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              busy,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_events
);

  localparam int unsigned CNT_W = $clog2(STACK_BEATS + RTI_EXTRA) + 1;
  localparam logic [CNT_W-1:0] STACK_LOAD = CNT_W'(STACK_BEATS - 1);
  localparam logic [CNT_W-1:0] RTI_LOAD   = CNT_W'(STACK_BEATS + RTI_EXTRA - 1);

  localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, busy: 1'b0};
  localparam hz_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1, busy: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1, busy: 1'b0};
  localparam hz_ctrl_t CTRL_JUMP   = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1, busy: 1'b0};
  localparam hz_ctrl_t CTRL_STACK  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1, busy: 1'b1};
  localparam hz_ctrl_t CTRL_REDIR  = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1, busy: 1'b1};

  hz_state_e        state_q;
  hz_state_e        state_d;
  hz_ctrl_t         ctrl;
  logic             load_use;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign load_use = ex_mem_read & ex_reg_write & id_valid &
                    (src_match(id_uses_src1, id_src1, ex_rd) |
                     src_match(id_uses_src2, id_src2, ex_rd));

  stall_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    ctrl         = CTRL_RUN;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_rti) begin
          ctrl         = CTRL_FREEZE;
          cnt_load     = 1'b1;
          cnt_load_val = RTI_LOAD;
          state_d      = RET_POP;
        end else if (ex_ret) begin
          ctrl         = CTRL_FREEZE;
          cnt_load     = 1'b1;
          cnt_load_val = STACK_LOAD;
          state_d      = RET_POP;
        end else if (ex_call) begin
          ctrl         = CTRL_FREEZE;
          cnt_load     = 1'b1;
          cnt_load_val = STACK_LOAD;
          state_d      = CALL_PUSH;
        end else if (ex_jump_taken) begin
          ctrl = CTRL_JUMP;
        end else if (load_use) begin
          ctrl = CTRL_FREEZE;
        end
      end
      // ex_* inputs are deliberately ignored while the stack is moving.
      CALL_PUSH, RET_POP: begin
        ctrl = CTRL_STACK;
        if (cnt_zero) begin
          state_d = REDIRECT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      REDIRECT: begin
        ctrl    = CTRL_REDIR;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      ctrl    = CTRL_RESET;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign ifid_write = ctrl.ifid_write;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign busy       = ctrl.busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (ctrl.ifid_flush && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  // Reads as zero during reset, before the synchronous clear lands.
  assign stall_cycles = reset ? 16'd0 : stall_q;
  assign flush_events = reset ? 16'd0 : flush_q;
`else
  assign stall_cycles = 16'd0;
  assign flush_events = 16'd0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed test-plan scenarios plus random traffic,
// checked against a schedule-queue reference model (perf counters when HAZARD_PERF_CNT_EN is defined).
module tb_ex_hazard_ctrl;

  localparam int unsigned SB = 2;
  localparam int unsigned RE = 1;
  localparam int unsigned EW = 37;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector layout: {pc_write, ifid_write, ifid_flush, idex_flush, busy}
  localparam logic [4:0] O_RESET  = 5'b00110;
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_FREEZE = 5'b00010;
  localparam logic [4:0] O_JUMP   = 5'b10110;
  localparam logic [4:0] O_STACK  = 5'b00011;
  localparam logic [4:0] O_REDIR  = 5'b10111;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [2:0]  id_src1;
  logic [2:0]  id_src2;
  logic        id_uses_src1;
  logic        id_uses_src2;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_call;
  logic        ex_ret;
  logic        ex_rti;
  logic        ex_jump_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        busy;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;

  logic [EW-1:0] exp_q[$];
  logic [4:0]    sched_q[$];
  int unsigned   m_stall;
  int unsigned   m_flush;
  int            total;
  int            bad;

  ex_hazard_ctrl #(
    .STACK_BEATS (SB),
    .RTI_EXTRA   (RE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_uses_src1  (id_uses_src1),
    .id_uses_src2  (id_uses_src2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_call       (ex_call),
    .ex_ret        (ex_ret),
    .ex_rti        (ex_rti),
    .ex_jump_taken (ex_jump_taken),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .busy          (busy),
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a stack instruction pre-commits its whole future as a list of cycles.
  task automatic schedule_stack(input int unsigned beats);
    for (int i = 0; i < int'(beats); i++) sched_q.push_back(O_STACK);
    sched_q.push_back(O_REDIR);
  endtask

  task automatic model_cycle(output logic [EW-1:0] e);
    logic [4:0] o;
    logic       lu;
    lu = ex_mem_read && ex_reg_write && id_valid &&
         ((id_uses_src1 && id_src1 == ex_rd) || (id_uses_src2 && id_src2 == ex_rd));
    if (reset) begin
      o = O_RESET;
      sched_q.delete();
    end else if (sched_q.size() > 0) begin
      o = sched_q.pop_front();
    end else if (ex_rti) begin
      o = O_FREEZE;
      schedule_stack(SB + RE);
    end else if (ex_ret || ex_call) begin
      o = O_FREEZE;
      schedule_stack(SB);
    end else if (ex_jump_taken) begin
      o = O_JUMP;
    end else if (lu) begin
      o = O_FREEZE;
    end else begin
      o = O_RUN;
    end
    if (reset) begin
      m_stall = 0;
      m_flush = 0;
      e = {o, 16'd0, 16'd0};
    end else begin
      e = {o, PERF ? 16'(m_stall) : 16'd0, PERF ? 16'(m_flush) : 16'd0};
      if (!o[4] && m_stall < 65535) m_stall++;
      if (o[2] && m_flush < 65535) m_flush++;
    end
  endtask

  // Driver tasks
  task automatic step();
    logic [EW-1:0] e;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0;
    id_uses_src1 = 1'b0; id_uses_src2 = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
    ex_mem_read = 1'b0; ex_call = 1'b0; ex_ret = 1'b0; ex_rti = 1'b0; ex_jump_taken = 1'b0;
  endtask

  task automatic randomize_inputs();
    reset         = ($urandom_range(0, 63) == 0);
    id_valid      = ($urandom_range(0, 4) != 0);
    id_src1       = 3'($urandom_range(0, 7));
    id_src2       = 3'($urandom_range(0, 7));
    id_uses_src1  = 1'($urandom_range(0, 1));
    id_uses_src2  = 1'($urandom_range(0, 1));
    ex_rd         = 3'($urandom_range(0, 7));
    ex_reg_write  = ($urandom_range(0, 3) != 0);
    ex_mem_read   = ($urandom_range(0, 2) == 0);
    ex_call       = ($urandom_range(0, 15) == 0);
    ex_ret        = ($urandom_range(0, 15) == 0);
    ex_rti        = ($urandom_range(0, 15) == 0);
    ex_jump_taken = ($urandom_range(0, 7) == 0);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_write, ifid_write, ifid_flush, idex_flush, busy, stall_cycles, flush_events};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got pc/ifw/iff/idf/busy=%b stall=%0d flush=%0d want %b stall=%0d flush=%0d",
                   $time, a[36:32], a[31:16], a[15:0], e[36:32], e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    m_stall = 0;
    m_flush = 0;
    quiet();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    quiet();
    step();

    // Load-use on src2: one bubble, then the bubble clears the load.
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd3;
    id_valid = 1'b1; id_uses_src2 = 1'b1; id_src2 = 3'd3;
    step();
    ex_mem_read = 1'b0;
    step();
    quiet();

    // Two RETs back to back from a clean reset; noise on ex_* during the pops.
    reset = 1'b1; step(); reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      ex_ret = 1'b1; step(); ex_ret = 1'b0;
      ex_call = 1'b1; ex_jump_taken = 1'b1; step(); step();
      quiet(); step(); step();
    end

    // RTI with a simultaneous CALL.
    ex_rti = 1'b1; ex_call = 1'b1; step(); quiet();
    for (int i = 0; i < 6; i++) step();

    // Taken jump while a load-use match is also present.
    ex_jump_taken = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd5;
    id_valid = 1'b1; id_uses_src1 = 1'b1; id_src1 = 3'd5;
    step(); quiet(); step();

    // Reset one cycle into a CALL push.
    ex_call = 1'b1; step(); ex_call = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) step();

    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      step();
    end
    quiet();
    for (int i = 0; i < 6; i++) step();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Stall/flush controller that consumes the instruction sitting in the ID/EX pipeline register and the operand fields of the instruction in decode.
Drives PC write-enable, the IF/ID write-enable and flush, and the ID/EX flush.
Handles load-use bubbles, taken jumps, and the multi-cycle stack sequences for CALL, RET and RTI. A 32-bit PC moves through the 16-bit stack one word per cycle.
Sits beside the decode stage, between the fetch/PC logic and the ID/EX register.

Parameters:
STACK_BEATS, 2, number of 16-bit stack words per PC push or pop (must be >= 1)
RTI_EXTRA, 1, extra pop cycles RTI needs to restore flags (>= 0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  decode stage holds a real instruction
id_src1  in  3  decode source register 1
id_src2  in  3  decode source register 2
id_uses_src1  in  1  decode instruction reads src1
id_uses_src2  in  1  decode instruction reads src2
ex_rd  in  3  destination register of the instruction in EX (ID/EX output)
ex_reg_write  in  1  EX instruction writes the register file
ex_mem_read  in  1  EX instruction is a load
ex_call  in  1  EX instruction is CALL
ex_ret  in  1  EX instruction is RET
ex_rti  in  1  EX instruction is RTI
ex_jump_taken  in  1  EX resolved a taken jump
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID (bubble)
idex_flush  out  1  drive ID/EX reset (bubble)
busy  out  1  FSM not in IDLE
stall_cycles  out  16  performance counter (optional feature)
flush_events  out  16  performance counter (optional feature)

Behaviour:
- reset is synchronous, active-high; clock is clk. While reset is high, outputs are: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, busy=0, counters 0. Next state is IDLE and cnt=0, including when reset is asserted mid-sequence.
- States: IDLE, CALL_PUSH, RET_POP, REDIRECT. Outputs are combinational from state and inputs. State and cnt (width clog2(STACK_BEATS+RTI_EXTRA)+1) are registered.
- IDLE default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, busy=0.
- IDLE priority, highest first: ex_rti > ex_ret > ex_call > ex_jump_taken > load-use.
- ex_rti: freeze this cycle (pc_write=0, ifid_write=0, idex_flush=1). Load cnt=STACK_BEATS+RTI_EXTRA-1. Go to RET_POP.
- ex_ret: same freeze, cnt=STACK_BEATS-1, go to RET_POP.
- ex_call: same freeze, cnt=STACK_BEATS-1, go to CALL_PUSH.
- ex_jump_taken: pc_write=1, ifid_flush=1, idex_flush=1 this cycle only. Stay IDLE.
- Load-use: condition is ex_mem_read & ex_reg_write & id_valid & ((id_uses_src1 & id_src1==ex_rd) | (id_uses_src2 & id_src2==ex_rd)). Response is pc_write=0, ifid_write=0, idex_flush=1 for one cycle. Stay IDLE; the bubble clears ex_mem_read on the next cycle.
- CALL_PUSH / RET_POP: pc_write=0, ifid_write=0, idex_flush=1, busy=1. If cnt==0, go to REDIRECT; otherwise cnt decrements. ex_* inputs are ignored while in these states.
- REDIRECT: pc_write=1 (PC loads the target or popped PC), ifid_flush=1, idex_flush=1, busy=1. Next state is IDLE.
- Timing, with N = pop/push count: detection cycle, then N cycles in PUSH/POP, then 1 REDIRECT cycle, then IDLE.
- ifid_flush and ifid_write are never both 1 in the same cycle.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cycles increments on every cycle with pc_write=0 and reset low. flush_events increments on every cycle with ifid_flush=1 and reset low. Both are 16-bit and saturate at 0xFFFF. Both clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - the state encoding (IDLE=0, CALL_PUSH=1, RET_POP=2, REDIRECT=3, 2-bit);
  - the default STACK_BEATS and RTI_EXTRA constants;
  - the register-address width (3).
- One sub-module, stall_counter: a loadable down-counter with a zero flag, used for cnt.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_valid=1, id_uses_src2=1, id_src2=3 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; busy stays 0.
- RET with defaults: ex_ret pulse at T -> pc_write=0 for T..T+2; REDIRECT at T+3 (pc_write=1, ifid_flush=1, idex_flush=1); IDLE at T+4.
- RTI with defaults: ex_rti at T -> 3 RET_POP cycles, REDIRECT at T+4. Simultaneous ex_call=1 at T is ignored (RTI priority).
- Taken jump with a simultaneous load-use match -> single cycle of pc_write=1, ifid_flush=1, idex_flush=1; no stall cycle.
- Reset asserted at T+1 of a CALL_PUSH sequence -> IDLE next cycle, cnt=0, no REDIRECT pulse.
- With HAZARD_PERF_CNT_EN: two RET sequences -> stall_cycles=6, flush_events=2.
